cv_cmd_parse: RTL and testbench

Receive-side counterpart of the result/message generator. Consumes ASCII bytes from the UART receiver one at a time and parses a command line of the form letter, optional hex digits, CR. Emits one packed command word per line to the command processing unit over a ready/valid handshake. Malformed lines produce an error command, so the downstream unit can still report an error message.

---
 rtl/cv_cmd_parse_if.sv | 22 ++
 rtl/cv_cmd_parse.sv | 158 +++++++++++++++
 tb/tb_cv_cmd_parse.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/cv_cmd_parse_if.sv
// Byte-in / command-out handshake bundle for the command-line parser.
// master = UART receiver and command unit side, slave = parser side.
interface cv_cmd_parse_if #(
  parameter int MAX_DIG = 16
);
  logic                     RX_RDY_T;
  logic [7:0]               RX_DATA_R;
  logic                     RX_RDY_R;
  logic                     CMD_RDY_T;
  logic [8+4*MAX_DIG-1:0]   CMD_DATA_T;
  logic                     CMD_RDY_R;

  modport master (
    output RX_RDY_T, RX_DATA_R, CMD_RDY_R,
    input  RX_RDY_R, CMD_RDY_T, CMD_DATA_T
  );

  modport slave (
    input  RX_RDY_T, RX_DATA_R, CMD_RDY_R,
    output RX_RDY_R, CMD_RDY_T, CMD_DATA_T
  );
endinterface

// File: rtl/cv_cmd_parse.sv
// ASCII command-line parser: letter, optional hex digits, CR -> {OP,CNT,OPERAND}.
// Optional macro CV_BACKSPACE_EN enables 0x08 as a line-editing backspace.
module cv_cmd_parse #(
  parameter int MAX_DIG = 16
) (
  input  logic              CLK,
  input  logic              RST,
  cv_cmd_parse_if.slave     bus
);
  localparam int W  = 4 * MAX_DIG;
  localparam int CW = 8 + W;

  typedef enum logic [1:0] {IDLE, ARG, SKIP, SEND} state_t;

  state_t          state_r, state_s;
  logic [W-1:0]    acc_r, acc_s;
  logic [4:0]      cnt_r, cnt_s;
  logic [2:0]      op_r, op_s;
  logic [CW-1:0]   data_r, data_s;
  logic            vld_r, vld_s;
  logic            rx_ok_r, rx_ok_s;
  logic [4:0]      hex_s;
  logic [7:0]      lc_s;
  logic            take_s;
  logic            line_ok_s;

  // {valid, nibble} for one ASCII hex digit
  function automatic logic [4:0] hex_decode(input logic [7:0] b);
    logic [4:0] r;
    if (b >= 8'h30 && b <= 8'h39) begin
      r = {1'b1, b[3:0]};
    end else if ((b >= 8'h41 && b <= 8'h46) || (b >= 8'h61 && b <= 8'h66)) begin
      r = {1'b1, b[3:0] + 4'd9};
    end else begin
      r = 5'b0_0000;
    end
    return r;
  endfunction

  assign bus.RX_RDY_R   = rx_ok_r;
  assign bus.CMD_RDY_T  = vld_r;
  assign bus.CMD_DATA_T = data_r;

  // next-state and datapath decode for the line parser
  always_comb begin
    state_s   = state_r;
    acc_s     = acc_r;
    cnt_s     = cnt_r;
    op_s      = op_r;
    data_s    = data_r;
    vld_s     = vld_r;
    rx_ok_s   = rx_ok_r;
    hex_s     = hex_decode(bus.RX_DATA_R);
    lc_s      = bus.RX_DATA_R | 8'h20;
    take_s    = bus.RX_RDY_T & rx_ok_r;
    line_ok_s = (op_r == 3'b001) ? (cnt_r != 5'd0) : (cnt_r == 5'd0);

    case (state_r)
      IDLE: begin
        if (!take_s) begin
          state_s = IDLE;
        end else if (lc_s == 8'h73 || lc_s == 8'h67 || lc_s == 8'h63) begin
          // case-folded 's', 'g', 'c'
          op_s    = (lc_s == 8'h73) ? 3'b001 : ((lc_s == 8'h67) ? 3'b010 : 3'b011);
          acc_s   = {W{1'b0}};
          cnt_s   = 5'd0;
          state_s = ARG;
        end else if (bus.RX_DATA_R == 8'h0D || bus.RX_DATA_R == 8'h0A ||
                     bus.RX_DATA_R == 8'h20) begin
          state_s = IDLE;
`ifdef CV_BACKSPACE_EN
        end else if (bus.RX_DATA_R == 8'h08) begin
          state_s = IDLE;
`endif
        end else begin
          state_s = SKIP;
        end
      end
      ARG: begin
        if (!take_s) begin
          state_s = ARG;
        end else if (hex_s[4]) begin
          if (cnt_r < 5'(MAX_DIG)) begin
            acc_s      = acc_r << 4;
            acc_s[3:0] = hex_s[3:0];
            cnt_s      = cnt_r + 5'd1;
          end else begin
            state_s = SKIP;
          end
        end else if (bus.RX_DATA_R == 8'h20 || bus.RX_DATA_R == 8'h0A) begin
          state_s = ARG;
        end else if (bus.RX_DATA_R == 8'h0D) begin
          data_s  = line_ok_s ? {op_r, cnt_r, acc_r} : {3'b111, 5'd0, {W{1'b0}}};
          vld_s   = 1'b1;
          rx_ok_s = 1'b0;
          state_s = SEND;
`ifdef CV_BACKSPACE_EN
        end else if (bus.RX_DATA_R == 8'h08) begin
          if (cnt_r != 5'd0) begin
            acc_s = acc_r >> 4;
            cnt_s = cnt_r - 5'd1;
          end else begin
            op_s    = 3'b000;
            state_s = IDLE;
          end
`endif
        end else begin
          state_s = SKIP;
        end
      end
      SKIP: begin
        if (take_s && bus.RX_DATA_R == 8'h0D) begin
          data_s  = {3'b111, 5'd0, {W{1'b0}}};
          vld_s   = 1'b1;
          rx_ok_s = 1'b0;
          state_s = SEND;
        end else begin
          state_s = SKIP;
        end
      end
      SEND: begin
        if (bus.CMD_RDY_R) begin
          vld_s   = 1'b0;
          rx_ok_s = 1'b1;
          state_s = IDLE;
        end else begin
          state_s = SEND;
        end
      end
      default: begin
        state_s = IDLE;
        vld_s   = 1'b0;
        rx_ok_s = 1'b1;
      end
    endcase
  end

  // parser state and registered outputs
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r <= IDLE;
      acc_r   <= {W{1'b0}};
      cnt_r   <= 5'd0;
      op_r    <= 3'b000;
      data_r  <= {CW{1'b0}};
      vld_r   <= 1'b0;
      rx_ok_r <= 1'b1;
    end else begin
      state_r <= state_s;
      acc_r   <= acc_s;
      cnt_r   <= cnt_s;
      op_r    <= op_s;
      data_r  <= data_s;
      vld_r   <= vld_s;
      rx_ok_r <= rx_ok_s;
    end
  end
endmodule

// File: tb/tb_cv_cmd_parse.sv
// Scoreboard bench for cv_cmd_parse: directed lines, expected words queued,
// monitor pops on each command handshake. Honours CV_BACKSPACE_EN.
module tb_cv_cmd_parse;
  localparam int MAX_DIG = 16;
  localparam int W  = 4 * MAX_DIG;
  localparam int CW = 8 + W;

  logic CLK = 1'b0;
  logic RST = 1'b1;

  cv_cmd_parse_if #(.MAX_DIG(MAX_DIG)) bus ();

  cv_cmd_parse #(.MAX_DIG(MAX_DIG)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  int vectors = 0;
  int errors  = 0;
  logic [CW-1:0] exp_q[$];
  logic          held = 1'b0;
  logic [CW-1:0] held_data;

  function automatic logic [CW-1:0] mk(input logic [2:0] op, input logic [4:0] cnt,
                                       input logic [W-1:0] opnd);
    return {op, cnt, opnd};
  endfunction

  task automatic check(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit done = 1'b0;
    bus.RX_DATA_R = b;
    bus.RX_RDY_T  = 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge CLK);
      if (bus.RX_RDY_R) begin
        @(posedge CLK);
        #1;
        done = 1'b1;
      end
    end
    bus.RX_RDY_T = 1'b0;
    if (!done) check("byte_timeout", {CW{1'b0}}, {{(CW-1){1'b0}}, 1'b1});
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  // CR, then command must be visible in the very next cycle
  task automatic send_cr();
    send_byte(8'h0D);
    check("cr_latency", {{(CW-1){1'b0}}, bus.CMD_RDY_T}, {{(CW-1){1'b0}}, 1'b1});
  endtask

  task automatic send_line(input string s, input logic [CW-1:0] exp);
    exp_q.push_back(exp);
    send_str(s);
    send_cr();
  endtask

  // monitor: stability while valid, scoreboard pop on handshake
  always @(negedge CLK) begin
    if (RST) begin
      held = 1'b0;
    end else if (bus.CMD_RDY_T) begin
      if (held) check("data_stable", bus.CMD_DATA_T, held_data);
      held      = 1'b1;
      held_data = bus.CMD_DATA_T;
      if (bus.CMD_RDY_R) begin
        held = 1'b0;
        if (exp_q.size() == 0) check("extra_cmd", bus.CMD_DATA_T, {CW{1'b0}});
        else check("cmd_word", bus.CMD_DATA_T, exp_q.pop_front());
      end
    end
  end

  localparam logic [CW-1:0] ERR = {3'b111, 5'd0, {W{1'b0}}};

  initial begin
    bus.RX_RDY_T  = 1'b0;
    bus.RX_DATA_R = 8'h00;
    bus.CMD_RDY_R = 1'b1;
    #12;
    check("rst_rx_rdy",  {{(CW-1){1'b0}}, bus.RX_RDY_R},  {{(CW-1){1'b0}}, 1'b1});
    check("rst_cmd_rdy", {{(CW-1){1'b0}}, bus.CMD_RDY_T}, {CW{1'b0}});
    check("rst_data",    bus.CMD_DATA_T, {CW{1'b0}});
    @(posedge CLK); #1 RST = 1'b0;

    // basic set command, one-cycle pulse with downstream ready
    send_line("S1A2B", mk(3'b001, 5'd4, 64'h1A2B));
    @(posedge CLK); #1;
    check("pulse_1cyc", {{(CW-1){1'b0}}, bus.CMD_RDY_T}, {CW{1'b0}});

    send_line("g", mk(3'b010, 5'd0, 64'h0));
    send_line("G5", ERR);
    send_line("c 0", ERR);
    send_line(" s\nfF ", mk(3'b001, 5'd2, 64'hFF));

    // 16 digits fit, 17 overflow
    send_line("S0123456789abcdef", mk(3'b001, 5'd16, 64'h0123_4567_89AB_CDEF));
    exp_q.push_back(ERR);
    send_byte("S");
    for (int i = 0; i < 17; i++) send_byte("F");
    send_cr();
    send_line("S1X2", ERR);
    send_line("Q", ERR);

    // backpressure: 'S' offered while command is held
    @(posedge CLK); #1 bus.CMD_RDY_R = 1'b0;
    send_line("C", mk(3'b011, 5'd0, 64'h0));
    bus.RX_DATA_R = "S";
    bus.RX_RDY_T  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      check("bp_rx_rdy",  {{(CW-1){1'b0}}, bus.RX_RDY_R},  {CW{1'b0}});
      check("bp_cmd_rdy", {{(CW-1){1'b0}}, bus.CMD_RDY_T}, {{(CW-1){1'b0}}, 1'b1});
      check("bp_data",    bus.CMD_DATA_T, mk(3'b011, 5'd0, 64'h0));
    end
    @(posedge CLK); #1 bus.CMD_RDY_R = 1'b1;
    send_byte("S");
    exp_q.push_back(mk(3'b001, 5'd2, 64'h12));
    send_str("12");
    send_cr();

    // asynchronous reset mid-line
    send_str("S12");
    #2 RST = 1'b1;
    #1;
    check("arst_rx_rdy",  {{(CW-1){1'b0}}, bus.RX_RDY_R},  {{(CW-1){1'b0}}, 1'b1});
    check("arst_cmd_rdy", {{(CW-1){1'b0}}, bus.CMD_RDY_T}, {CW{1'b0}});
    check("arst_data",    bus.CMD_DATA_T, {CW{1'b0}});
    @(posedge CLK); #1 RST = 1'b0;
    send_line("G", mk(3'b010, 5'd0, 64'h0));

`ifdef CV_BACKSPACE_EN
    send_line("S12\x083", mk(3'b001, 5'd2, 64'h13));
    send_line("S\x08G", mk(3'b010, 5'd0, 64'h0));
`else
    send_line("S12\x083", ERR);
`endif

    repeat (5) @(posedge CLK);
    #1;
    check("queue_empty", CW'(exp_q.size()), {CW{1'b0}});
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule
